// File: rtl/me_pkg.sv
// Shared constants, FSM state encoding and result payload for the ME pixel feeder.
// The optional result watchdog is enabled by defining ME_TIMEOUT_EN.
package me_pkg;

    localparam int unsigned WORD_WIDETH   = 8;
    localparam int unsigned PIX_PER_WORD  = 4;
    localparam int unsigned DATA_W        = WORD_WIDETH * PIX_PER_WORD;
    localparam int unsigned BLK           = 16;
    localparam int unsigned SR            = 8;
    localparam int unsigned WIN           = BLK + 2 * SR;
    localparam int unsigned ADDR_W        = 20;
    localparam int unsigned MV_W          = 6;
    localparam int unsigned SAD_W         = 16;

    localparam int unsigned BLK_ROW_WORDS = BLK / PIX_PER_WORD;
    localparam int unsigned WIN_ROW_WORDS = WIN / PIX_PER_WORD;
    localparam int unsigned BLK_WORDS     = BLK_ROW_WORDS * BLK;
    localparam int unsigned WIN_WORDS     = WIN_ROW_WORDS * WIN;
    localparam int unsigned COL_W         = $clog2(WIN_ROW_WORDS);
    localparam int unsigned WCNT_W        = $clog2(WIN_WORDS);

    // Result frame as shifted in LSB-first after the start bit
    localparam int unsigned RES_BITS      = MV_W * 2 + SAD_W;
    localparam int unsigned RES_CNT_W     = $clog2(RES_BITS);
    localparam int unsigned MVX_OFS       = 0;
    localparam int unsigned MVY_OFS       = MV_W;
    localparam int unsigned SAD_OFS       = 2 * MV_W;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_LOAD_CUR = 3'd2,
        ST_LOAD_WIN = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_RECV     = 3'd5
    } me_state_e;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [MV_W-1:0]  mv_y;
        logic [MV_W-1:0]  mv_x;
    } me_result_t;

endpackage

// File: rtl/me_pixel_feeder_if.sv
// Pin-level bus between the feeder, frame memory and the ME core.
interface me_pixel_feeder_if;
    import me_pkg::*;

    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              chip_init;
    logic [DATA_W-1:0] chip_data;
    logic              chip_res;

    modport master (
        output mem_rd, mem_addr, chip_init, chip_data,
        input  mem_rdata, chip_res
    );

    modport slave (
        input  mem_rd, mem_addr, chip_init, chip_data,
        output mem_rdata, chip_res
    );

endinterface

// File: rtl/me_res_deser.sv
// Serial result receiver: start-bit detect, bit counter and LSB-first shift register.
module me_res_deser
    import me_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_arm,
    input  logic       i_recv,
    input  logic       i_bit,
    output logic       o_start_c,
    output logic       o_frame_valid_c,
    output me_result_t o_res_c
);

    logic [RES_BITS-2:0]  r_shift;
    logic [RES_CNT_W-1:0] r_cnt;
    logic [RES_BITS-1:0]  w_frame;

    assign o_start_c       = i_arm & i_bit;
    assign o_frame_valid_c = i_recv && (r_cnt == RES_CNT_W'(RES_BITS - 1));

    // Last bit is still on the line when the frame completes, so merge it in directly
    assign w_frame = {i_bit, r_shift};

    always_comb begin
        o_res_c      = '0;
        o_res_c.mv_x = w_frame[MVX_OFS +: MV_W];
        o_res_c.mv_y = w_frame[MVY_OFS +: MV_W];
        o_res_c.sad  = w_frame[SAD_OFS +: SAD_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_recv) begin
            r_shift <= w_frame[RES_BITS-1:1];
            r_cnt   <= r_cnt + 1'b1;
        end else begin
            r_cnt   <= '0;
        end
    end

endmodule

// File: rtl/me_pixel_feeder.sv
// Host-side feeder for the block-matching ME core: streams block + window, then collects the result.
// Define ME_TIMEOUT_EN to enable the result watchdog (TIMEOUT_CYC cycles in WAIT_RES).
module me_pixel_feeder
    import me_pkg::*;
`ifdef ME_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYC = 4096
)
`endif
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       cur_base,
    input  logic [ADDR_W-1:0]       win_base,
    input  logic [ADDR_W-1:0]       stride,
    me_pixel_feeder_if.master       bus,
    output logic                    busy,
    output logic                    done,
    output logic signed [MV_W-1:0]  mv_x,
    output logic signed [MV_W-1:0]  mv_y,
    output logic [SAD_W-1:0]        sad,
    output logic                    err
);

    me_state_e         r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cur_base, w_cur_base_nxt;
    logic [ADDR_W-1:0] r_win_base, w_win_base_nxt;
    logic [ADDR_W-1:0] r_stride, w_stride_nxt;
    logic [ADDR_W-1:0] r_row_off, w_row_off_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [COL_W-1:0]  r_col, w_col_nxt;
    logic [WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
    logic              r_mem_rd, w_mem_rd_nxt;
    logic              r_chip_init, w_chip_init_nxt;
    logic              r_fwd;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    me_result_t        r_res, w_res_nxt;

    logic [COL_W-1:0]  w_col_last;
    logic [ADDR_W-1:0] w_base;
    logic [COL_W-1:0]  w_col_adv;
    logic [ADDR_W-1:0] w_off_adv;
    logic [ADDR_W-1:0] w_addr_adv;

    logic              w_start_bit;
    logic              w_frame_valid;
    me_result_t        w_des_res;

`ifdef ME_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
    logic              r_err, w_err_nxt;
`endif

    me_res_deser u_deser (
        .clk             (clk),
        .rst             (rst),
        .i_arm           (r_state == ST_WAIT_RES),
        .i_recv          (r_state == ST_RECV),
        .i_bit           (bus.chip_res),
        .o_start_c       (w_start_bit),
        .o_frame_valid_c (w_frame_valid),
        .o_res_c         (w_des_res)
    );

    // Next raster address; row*stride is kept as a running offset
    always_comb begin
        w_col_last = (r_state == ST_LOAD_WIN) ? COL_W'(WIN_ROW_WORDS - 1)
                                              : COL_W'(BLK_ROW_WORDS - 1);
        w_base     = (r_state == ST_LOAD_WIN) ? r_win_base : r_cur_base;
        if (r_col == w_col_last) begin
            w_col_adv = '0;
            w_off_adv = r_row_off + r_stride;
        end else begin
            w_col_adv = r_col + 1'b1;
            w_off_adv = r_row_off;
        end
        w_addr_adv = w_base + w_off_adv + ADDR_W'(w_col_adv);
    end

    // FSM next-state and registered-output values
    always_comb begin
        w_state_nxt     = r_state;
        w_cur_base_nxt  = r_cur_base;
        w_win_base_nxt  = r_win_base;
        w_stride_nxt    = r_stride;
        w_row_off_nxt   = r_row_off;
        w_mem_addr_nxt  = r_mem_addr;
        w_col_nxt       = r_col;
        w_wcnt_nxt      = r_wcnt;
        w_mem_rd_nxt    = 1'b0;
        w_chip_init_nxt = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_res_nxt       = r_res;
`ifdef ME_TIMEOUT_EN
        w_tmo_nxt       = '0;
        w_err_nxt       = r_err;
`endif

        case (r_state)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped
                if (start && !r_done) begin
                    w_state_nxt     = ST_INIT;
                    w_cur_base_nxt  = cur_base;
                    w_win_base_nxt  = win_base;
                    w_stride_nxt    = stride;
                    w_row_off_nxt   = '0;
                    w_col_nxt       = '0;
                    w_wcnt_nxt      = '0;
                    w_mem_addr_nxt  = cur_base;
                    w_mem_rd_nxt    = 1'b1;
                    w_chip_init_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_res_nxt       = '0;
`ifdef ME_TIMEOUT_EN
                    w_err_nxt       = 1'b0;
`endif
                end
            end

            ST_INIT, ST_LOAD_CUR: begin
                w_mem_rd_nxt = 1'b1;
                if (r_wcnt == WCNT_W'(BLK_WORDS - 1)) begin
                    w_state_nxt    = ST_LOAD_WIN;
                    w_row_off_nxt  = '0;
                    w_col_nxt      = '0;
                    w_wcnt_nxt     = '0;
                    w_mem_addr_nxt = r_win_base;
                end else begin
                    w_state_nxt    = ST_LOAD_CUR;
                    w_row_off_nxt  = w_off_adv;
                    w_col_nxt      = w_col_adv;
                    w_wcnt_nxt     = r_wcnt + 1'b1;
                    w_mem_addr_nxt = w_addr_adv;
                end
            end

            ST_LOAD_WIN: begin
                if (r_wcnt == WCNT_W'(WIN_WORDS - 1)) begin
                    w_state_nxt    = ST_WAIT_RES;
                end else begin
                    w_mem_rd_nxt   = 1'b1;
                    w_row_off_nxt  = w_off_adv;
                    w_col_nxt      = w_col_adv;
                    w_wcnt_nxt     = r_wcnt + 1'b1;
                    w_mem_addr_nxt = w_addr_adv;
                end
            end

            ST_WAIT_RES: begin
                if (w_start_bit) begin
                    w_state_nxt = ST_RECV;
                end
`ifdef ME_TIMEOUT_EN
                else if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_res_nxt   = '0;
                end else begin
                    w_tmo_nxt   = r_tmo + 1'b1;
                end
`endif
            end

            ST_RECV: begin
                if (w_frame_valid) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_res_nxt   = w_des_res;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cur_base  <= '0;
            r_win_base  <= '0;
            r_stride    <= '0;
            r_row_off   <= '0;
            r_mem_addr  <= '0;
            r_col       <= '0;
            r_wcnt      <= '0;
            r_mem_rd    <= 1'b0;
            r_chip_init <= 1'b0;
            r_fwd       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_base  <= w_cur_base_nxt;
            r_win_base  <= w_win_base_nxt;
            r_stride    <= w_stride_nxt;
            r_row_off   <= w_row_off_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_col       <= w_col_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_chip_init <= w_chip_init_nxt;
            r_fwd       <= r_mem_rd;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_res       <= w_res_nxt;
        end
    end

`ifdef ME_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_tmo <= w_tmo_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // Memory returns data one cycle after the read; forward it in that cycle, zero otherwise
    assign bus.chip_data = r_fwd ? bus.mem_rdata : '0;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.chip_init = r_chip_init;

    assign busy = r_busy;
    assign done = r_done;
    assign mv_x = r_res.mv_x;
    assign mv_y = r_res.mv_y;
    assign sad  = r_res.sad;

endmodule

// File: tb/tb_me_pixel_feeder.sv
// Randomized self-checking bench for me_pixel_feeder against a raster-order address/data model.
module tb_me_pixel_feeder;
    import me_pkg::*;

    localparam int TB_BLK       = 16;
    localparam int TB_WIN       = 32;
    localparam int TB_BLK_WORDS = TB_BLK * TB_BLK / 4;
    localparam int TB_WIN_WORDS = TB_WIN * TB_WIN / 4;
    localparam int TB_STREAM    = TB_BLK_WORDS + TB_WIN_WORDS;
    localparam int MODE_NORM    = 0;
    localparam int MODE_NOISE   = 1;
    localparam int MODE_RESET   = 2;
    localparam int MODE_TMO     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] cur_base, win_base, stride;
    logic              busy, done, err;
    logic [MV_W-1:0]   mv_x, mv_y;
    logic [SAD_W-1:0]  sad;

    int n_checks = 0;
    int n_fail   = 0;

    me_pixel_feeder_if bus ();

`ifdef ME_TIMEOUT_EN
    me_pixel_feeder #(.TIMEOUT_CYC(16)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cur_base (cur_base),
        .win_base (win_base),
        .stride   (stride),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .mv_x     (mv_x),
        .mv_y     (mv_y),
        .sad      (sad),
        .err      (err)
    );
`else
    me_pixel_feeder u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cur_base (cur_base),
        .win_base (win_base),
        .stride   (stride),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .mv_x     (mv_x),
        .mv_y     (mv_y),
        .sad      (sad),
        .err      (err)
    );
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'(a) * 32'h9E3779B1 + 32'h5A5A0F0F;
    endfunction

    // Frame memory: data one cycle after the read strobe, garbage otherwise
    always @(posedge clk)
        bus.mem_rdata <= bus.mem_rd ? mem_word(bus.mem_addr) : $urandom();

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rd"}, 32'(bus.mem_rd), 32'd0);
        check({tag, "_init"}, 32'(bus.chip_init), 32'd0);
        check({tag, "_data"}, bus.chip_data, 32'd0);
    endtask

    task automatic run_frame(input logic [ADDR_W-1:0] cb, input logic [ADDR_W-1:0] wb,
                             input logic [ADDR_W-1:0] st, input int mode,
                             input logic [RES_BITS-1:0] frame, input int gap);
        logic [ADDR_W-1:0] addrq[$];
        logic [31:0]       exp_data;

        for (int r = 0; r < TB_BLK; r++)
            for (int c = 0; c < TB_BLK / 4; c++)
                addrq.push_back(cb + ADDR_W'(r) * st + ADDR_W'(c));
        for (int r = 0; r < TB_WIN; r++)
            for (int c = 0; c < TB_WIN / 4; c++)
                addrq.push_back(wb + ADDR_W'(r) * st + ADDR_W'(c));

        start    = 1'b1;
        cur_base = cb;
        win_base = wb;
        stride   = st;
        step();
        start    = 1'b0;
        cur_base = ADDR_W'($urandom());
        win_base = ADDR_W'($urandom());
        stride   = ADDR_W'($urandom());
        check("err_cleared", 32'(err), 32'd0);

        for (int cyc = 1; cyc <= TB_STREAM; cyc++) begin
            exp_data = (cyc >= 2) ? mem_word(addrq[cyc-2]) : 32'd0;
            check("mem_rd", 32'(bus.mem_rd), 32'd1);
            check("mem_addr", 32'(bus.mem_addr), 32'(addrq[cyc-1]));
            check("chip_init", 32'(bus.chip_init), 32'(cyc == 1));
            check("chip_data", bus.chip_data, exp_data);
            check("busy", 32'(busy), 32'd1);
            check("done", 32'(done), 32'd0);
            if (mode == MODE_RESET && cyc == 101) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_quiet("abort");
                return;
            end
            if (mode == MODE_NOISE) begin
                start        = (cyc == 150);
                cur_base     = ADDR_W'($urandom());
                bus.chip_res = (cyc < 319) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            step();
        end
        start        = 1'b0;
        bus.chip_res = 1'b0;
        check("tail_rd", 32'(bus.mem_rd), 32'd0);
        check("tail_data", bus.chip_data, mem_word(addrq[TB_STREAM-1]));
        check("tail_busy", 32'(busy), 32'd1);

        if (mode == MODE_TMO) begin
            for (int k = 0; k < 16; k++) begin
                check("tmo_wait_done", 32'(done), 32'd0);
                check("tmo_wait_busy", 32'(busy), 32'd1);
                step();
            end
            check("tmo_done", 32'(done), 32'd1);
            check("tmo_err", 32'(err), 32'd1);
            check("tmo_busy", 32'(busy), 32'd0);
            check("tmo_mv_x", 32'(mv_x), 32'd0);
            check("tmo_mv_y", 32'(mv_y), 32'd0);
            check("tmo_sad", 32'(sad), 32'd0);
            step();
            check("tmo_done_pulse", 32'(done), 32'd0);
            return;
        end

        for (int g = 0; g < gap; g++) begin
            check("gap_busy", 32'(busy), 32'd1);
            step();
        end
        bus.chip_res = 1'b1;
        step();
        for (int i = 0; i < RES_BITS; i++) begin
            bus.chip_res = frame[i];
            check("recv_busy", 32'(busy), 32'd1);
            check("recv_done", 32'(done), 32'd0);
            step();
        end
        bus.chip_res = 1'b0;
        check("res_done", 32'(done), 32'd1);
        check("res_busy", 32'(busy), 32'd0);
        check("res_mv_x", 32'(mv_x), 32'(frame[5:0]));
        check("res_mv_y", 32'(mv_y), 32'(frame[11:6]));
        check("res_sad", 32'(sad), 32'(frame[27:12]));
        check("res_err", 32'(err), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_quiet("post");
        check("hold_mv_x", 32'(mv_x), 32'(frame[5:0]));
        check("hold_mv_y", 32'(mv_y), 32'(frame[11:6]));
        check("hold_sad", 32'(sad), 32'(frame[27:12]));
        step();
        check("post2_busy", 32'(busy), 32'd0);
        check("post2_rd", 32'(bus.mem_rd), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        cur_base     = '0;
        win_base     = '0;
        stride       = '0;
        bus.chip_res = 1'b0;
        step();
        step();
        check_quiet("reset");
        check("reset_mv_x", 32'(mv_x), 32'd0);
        check("reset_mv_y", 32'(mv_y), 32'd0);
        check("reset_sad", 32'(sad), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        step();

        // Directed frame: mv_x=5, mv_y=-3, sad=0x0123
        run_frame(ADDR_W'(32'h100), ADDR_W'(32'h2000), ADDR_W'(40), MODE_NORM,
                  {16'h0123, 6'h3D, 6'h05}, 3);
        check("dir_mv_x", 32'(mv_x), 32'd5);
        check("dir_mv_y", 32'(mv_y), 32'h3D);
        check("dir_sad", 32'(sad), 32'h0123);

        run_frame(ADDR_W'($urandom()), ADDR_W'($urandom()), ADDR_W'($urandom_range(8, 1000)),
                  MODE_NOISE, RES_BITS'($urandom()), $urandom_range(0, 10));

        run_frame(ADDR_W'($urandom()), ADDR_W'($urandom()), ADDR_W'($urandom_range(8, 1000)),
                  MODE_RESET, RES_BITS'($urandom()), 0);
        run_frame(ADDR_W'($urandom()), ADDR_W'($urandom()), ADDR_W'($urandom_range(8, 1000)),
                  MODE_NORM, RES_BITS'($urandom()), $urandom_range(0, 10));

`ifdef ME_TIMEOUT_EN
        run_frame(ADDR_W'($urandom()), ADDR_W'($urandom()), ADDR_W'($urandom_range(8, 1000)),
                  MODE_TMO, '0, 0);
        run_frame(ADDR_W'($urandom()), ADDR_W'($urandom()), ADDR_W'($urandom_range(8, 1000)),
                  MODE_NORM, RES_BITS'($urandom()), $urandom_range(0, 10));
`endif

        for (int n = 0; n < 4; n++) begin
            run_frame(ADDR_W'($urandom()), ADDR_W'($urandom()), ADDR_W'($urandom_range(1, 4000)),
                      MODE_NORM, RES_BITS'($urandom()), $urandom_range(0, 10));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
